// File: rtl/project_activator_pkg.sv
// Shared types, register offsets, field positions and counter widths for project_activator.
package project_activator_pkg;

  typedef enum logic [1:0] {OFF, DRAIN, ON} state_e;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_GUARD  = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_WDOG   = 4'hC;

  localparam int unsigned IDX_W         = 5;
  localparam int unsigned CTRL_EN_BIT   = 8;
  localparam int unsigned STAT_BUSY_BIT = 8;
  localparam int unsigned STAT_ON_BIT   = 9;
  localparam int unsigned STAT_ERR_BIT  = 16;
  localparam int unsigned STAT_WDOG_BIT = 17;

  // Only idx and en exist in CTRL; everything else reads back as zero.
  localparam logic [31:0] CTRL_MASK = 32'h0000_011F;

  localparam int unsigned GUARD_W = 16;
  localparam int unsigned WDOG_W  = 24;

  // Byte-lane merge of write data onto an existing register value.
  function automatic logic [31:0] merge_bytes(logic [31:0] old_val, logic [31:0] wdata,
                                              logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/project_activator_if.sv
// Wishbone slave bus bundle for project_activator.
interface project_activator_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/project_activator_regs.sv
// Wishbone decode, single-cycle ack, readback and register storage.
// Watchdog register present only with PROJECT_ACTIVATOR_WATCHDOG_EN defined.
module project_activator_regs
  import project_activator_pkg::*;
#(
  parameter int unsigned        NUM_PROJECTS = 8,
  parameter logic [31:0]        BASE_ADDR    = 32'h3000_0000,
  parameter logic [GUARD_W-1:0] GUARD_RESET  = 16'd16
) (
  input  logic               clk,
  input  logic               rst,
  project_activator_if.slave bus,
  input  logic [IDX_W-1:0]   cur_idx,
  input  logic               busy,
  input  logic               on,
  input  logic               wdog_fire,
  output logic               ctrl_wr,
  output logic [IDX_W-1:0]   ctrl_idx,
  output logic               ctrl_en,
  output logic [GUARD_W-1:0] guard,
  output logic               wdog_wr,
  output logic [WDOG_W-1:0]  wdog_val,
  output logic [WDOG_W-1:0]  wdog_timeout
);

  logic               ack_q;
  logic [31:0]        dat_q;
  logic [31:0]        ctrl_q;
  logic [GUARD_W-1:0] guard_q;
  logic               err_q, err_d;
  logic               wdog_fired;
  logic               hit, wr, ctrl_try, ctrl_bad, guard_wr, err_clr;
  logic [3:0]         off;
  logic [31:0]        ctrl_merged, guard_merged, rdata;
  logic               unused_adr;

  assign unused_adr = ^bus.wbs_adr_i[1:0];

  // A hit while ack is high is dropped so acks never run back to back.
  assign hit = bus.wbs_stb_i && bus.wbs_cyc_i && !ack_q &&
               (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr  = hit && bus.wbs_we_i;
  assign off = {bus.wbs_adr_i[3:2], 2'b00};

  assign ctrl_merged  = merge_bytes(ctrl_q, bus.wbs_dat_i, bus.wbs_sel_i) & CTRL_MASK;
  assign guard_merged = merge_bytes({16'b0, guard_q}, bus.wbs_dat_i, bus.wbs_sel_i);

  assign ctrl_try = wr && (off == REG_CTRL);
  assign ctrl_bad = ctrl_try && ctrl_merged[CTRL_EN_BIT] &&
                    ({27'b0, ctrl_merged[IDX_W-1:0]} >= 32'(NUM_PROJECTS));
  assign ctrl_wr  = ctrl_try && !ctrl_bad;
  assign ctrl_idx = ctrl_merged[IDX_W-1:0];
  assign ctrl_en  = ctrl_merged[CTRL_EN_BIT];
  assign guard_wr = wr && (off == REG_GUARD);
  assign guard    = guard_q;
  assign err_clr  = wr && (off == REG_STATUS) && bus.wbs_sel_i[2] &&
                    bus.wbs_dat_i[STAT_ERR_BIT];

  // Error flag: a rejected write beats a simultaneous W1C clear.
  always_comb begin
    err_d = err_q;
    if (ctrl_bad) err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  // Readback mux for the addressed register.
  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL:   rdata = ctrl_q;
      REG_GUARD:  rdata = {16'b0, guard_q};
      REG_STATUS: begin
        rdata[IDX_W-1:0]     = cur_idx;
        rdata[STAT_BUSY_BIT] = busy;
        rdata[STAT_ON_BIT]   = on;
        rdata[STAT_ERR_BIT]  = err_q;
        rdata[STAT_WDOG_BIT] = wdog_fired;
      end
      REG_WDOG:   rdata = {8'b0, wdog_timeout};
      default:    rdata = '0;
    endcase
  end

  // Bus handshake and register storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      ctrl_q  <= '0;
      guard_q <= GUARD_RESET;
      err_q   <= 1'b0;
    end else begin
      ack_q <= hit;
      dat_q <= (hit && !bus.wbs_we_i) ? rdata : '0;
      if (ctrl_wr) ctrl_q <= ctrl_merged;
      else if (wdog_fire) ctrl_q[CTRL_EN_BIT] <= 1'b0;
      if (guard_wr) guard_q <= guard_merged[GUARD_W-1:0];
      err_q <= err_d;
    end
  end

`ifdef PROJECT_ACTIVATOR_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q;
  logic              wdog_fired_q;
  logic [31:0]       wdog_merged;

  assign wdog_merged  = merge_bytes({8'b0, wdog_q}, bus.wbs_dat_i, bus.wbs_sel_i);
  assign wdog_wr      = wr && (off == REG_WDOG);
  assign wdog_val     = wdog_merged[WDOG_W-1:0];
  assign wdog_timeout = wdog_q;
  assign wdog_fired   = wdog_fired_q;

  // Watchdog timeout storage and fired flag (set beats W1C clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q       <= '0;
      wdog_fired_q <= 1'b0;
    end else begin
      if (wdog_wr) wdog_q <= wdog_val;
      if (wdog_fire) wdog_fired_q <= 1'b1;
      else if (wr && (off == REG_STATUS) && bus.wbs_sel_i[2] && bus.wbs_dat_i[STAT_WDOG_BIT])
        wdog_fired_q <= 1'b0;
    end
  end
`else
  assign wdog_wr      = 1'b0;
  assign wdog_val     = '0;
  assign wdog_timeout = '0;
  assign wdog_fired   = 1'b0;
`endif

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;

endmodule

// File: rtl/project_activator.sv
// Break-before-make one-hot project enable controller with a Wishbone register file.
// Optional watchdog built when PROJECT_ACTIVATOR_WATCHDOG_EN is defined.
module project_activator
  import project_activator_pkg::*;
#(
  parameter int unsigned        NUM_PROJECTS = 8,
  parameter logic [31:0]        BASE_ADDR    = 32'h3000_0000,
  parameter logic [GUARD_W-1:0] GUARD_RESET  = 16'd16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  project_activator_if.slave      wbs,
  output logic [NUM_PROJECTS-1:0] active_o,
  output logic                    busy_o,
  output logic                    irq_o
);

  state_e                  state_q, state_d;
  logic [GUARD_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_PROJECTS-1:0] active_q, active_d;
  logic                    busy_q, busy_d, irq_q, irq_d;
  logic                    ctrl_wr, ctrl_en, wdog_wr, wdog_fire;
  logic [IDX_W-1:0]        ctrl_idx;
  logic [GUARD_W-1:0]      guard;
  logic [WDOG_W-1:0]       wdog_val, wdog_timeout;

  project_activator_regs #(
    .NUM_PROJECTS (NUM_PROJECTS),
    .BASE_ADDR    (BASE_ADDR),
    .GUARD_RESET  (GUARD_RESET)
  ) u_regs (
    .clk          (wb_clk_i),
    .rst          (wb_rst_i),
    .bus          (wbs),
    .cur_idx      (idx_q),
    .busy         (state_q == DRAIN),
    .on           (state_q == ON),
    .wdog_fire    (wdog_fire),
    .ctrl_wr      (ctrl_wr),
    .ctrl_idx     (ctrl_idx),
    .ctrl_en      (ctrl_en),
    .guard        (guard),
    .wdog_wr      (wdog_wr),
    .wdog_val     (wdog_val),
    .wdog_timeout (wdog_timeout)
  );

`ifdef PROJECT_ACTIVATOR_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
`else
  logic unused_wdog;
  assign unused_wdog = wdog_wr ^ (^wdog_val) ^ (^wdog_timeout);
`endif

  // Next state: accepted CTRL writes preempt the guard countdown and the watchdog.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    irq_d     = 1'b0;
    wdog_fire = 1'b0;
`ifdef PROJECT_ACTIVATOR_WATCHDOG_EN
    wdog_cnt_d = wdog_cnt_q;
`endif
    if (ctrl_wr) begin
      if (ctrl_en) begin
        idx_d   = ctrl_idx;
        cnt_d   = guard;
        state_d = DRAIN;
      end else begin
        state_d = OFF;
      end
    end else begin
      case (state_q)
        DRAIN: begin
          if (cnt_q == '0) begin
            state_d = ON;
            irq_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ON: begin
`ifdef PROJECT_ACTIVATOR_WATCHDOG_EN
          // Fire in the last permitted ON cycle so the project stays on exactly WDOG cycles.
          if (!wdog_wr && (wdog_timeout != '0) && (wdog_cnt_q <= 24'd1)) begin
            state_d   = OFF;
            wdog_fire = 1'b1;
            irq_d     = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
`ifdef PROJECT_ACTIVATOR_WATCHDOG_EN
    if (wdog_wr) wdog_cnt_d = wdog_val;
    else if ((state_d == ON) && (state_q != ON)) wdog_cnt_d = wdog_timeout;
    else if ((state_q == ON) && (wdog_timeout != '0) && (wdog_cnt_q != '0))
      wdog_cnt_d = wdog_cnt_q - 1'b1;
`endif
    active_d = (state_d == ON) ? (NUM_PROJECTS'(1) << idx_d) : '0;
    busy_d   = (state_d == DRAIN);
  end

  // State, counters and registered outputs; reset clears enables immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      idx_q    <= '0;
      active_q <= '0;
      busy_q   <= 1'b0;
      irq_q    <= 1'b0;
`ifdef PROJECT_ACTIVATOR_WATCHDOG_EN
      wdog_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      irq_q    <= irq_d;
`ifdef PROJECT_ACTIVATOR_WATCHDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
`endif
    end
  end

  assign active_o = active_q;
  assign busy_o   = busy_q;
  assign irq_o    = irq_q;

endmodule
